// File: rtl/depth_test_pkg.sv
// Shared types for the depth-test pipeline: signed raster coordinates,
// the far-plane depth value and the controller state encoding.
package depth_test_pkg;

    typedef logic signed [12:0] i13;
    typedef i13 [2:0] vec3_i13;

    localparam logic [11:0] DEPTH_FAR = 12'hFFF;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        CLEAR
    } state_e;

endpackage

// File: rtl/depth_test_bram.sv
// Simple dual-port 12-bit depth store with a registered read; a read and a
// write to the same address in one cycle return the old contents.
module depth_bram #(
    parameter int DEPTH  = 76800,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [11:0]       wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [11:0]       rdata_o
);

    logic [11:0] mem [DEPTH];
    logic [11:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/depth_test.sv
// Pipelined depth test: A (register + BRAM read), B (read data), C (compare
// result + depth write), D (framebuffer write strobe), plus a full depth clear.
module depth_test
    import depth_test_pkg::*;
#(
    parameter int MAX_W  = 320,
    parameter int MAX_H  = 240,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frag_valid,
    output logic              frag_ready,
    input  vec3_i13           rast_pt,
    input  i13                image_width,
    input  i13                image_height,
    input  logic              clear_start,
    output logic              busy,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [31:0]       pass_count
);

    localparam int DEPTH = MAX_W * MAX_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state_q;
    logic              clearPending_q;
    logic [ADDR_W-1:0] clrCnt_q;

    logic              aValid_q, aInb_q;
    logic [11:0]       aZ_q;
    logic [ADDR_W-1:0] aAddr_q;
    logic              bValid_q, bInb_q;
    logic [11:0]       bZ_q;
    logic [ADDR_W-1:0] bAddr_q;
    logic              cValid_q, cPass_q;
    logic [11:0]       cZ_q;
    logic [ADDR_W-1:0] cAddr_q;
    logic              dValid_q, dPass_q;
    logic [11:0]       dZ_q;
    logic [ADDR_W-1:0] dAddr_q;
    logic [31:0]       passCount_q;

    i13                fx, fy, fz;
    logic              accept, aInb_d, cPass_d;
    logic [ADDR_W-1:0] aAddr_d;
    logic [11:0]       bramRdata, effDepth;
    logic              bramWe;
    logic [ADDR_W-1:0] bramWaddr;
    logic [11:0]       bramWdata;

    assign fx = rast_pt[0];
    assign fy = rast_pt[1];
    assign fz = rast_pt[2];

    assign frag_ready = (state_q == RUN) && !clearPending_q;
    assign busy       = (state_q != RUN) || clearPending_q;
    assign accept     = frag_valid && frag_ready;

    assign aInb_d  = !fx[12] && !fy[12] && !fz[12] && (fx < image_width) && (fy < image_height);
    assign aAddr_d = ADDR_W'(fy) * ADDR_W'(image_width) + ADDR_W'(fx);

    // The two younger passed writes may not be in the BRAM yet; the newest one wins.
    always_comb begin
        effDepth = bramRdata;
        if (dPass_q && (dAddr_q == bAddr_q)) begin
            effDepth = dZ_q;
        end
        if (cPass_q && (cAddr_q == bAddr_q)) begin
            effDepth = cZ_q;
        end
        cPass_d = bValid_q && bInb_q && (bZ_q < effDepth);
    end

    always_comb begin
        bramWe    = cPass_q;
        bramWaddr = cAddr_q;
        bramWdata = cZ_q;
        if (state_q == CLEAR) begin
            bramWe    = 1'b1;
            bramWaddr = clrCnt_q;
            bramWdata = DEPTH_FAR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aValid_q    <= 1'b0;
            aInb_q      <= 1'b0;
            aZ_q        <= '0;
            aAddr_q     <= '0;
            bValid_q    <= 1'b0;
            bInb_q      <= 1'b0;
            bZ_q        <= '0;
            bAddr_q     <= '0;
            cValid_q    <= 1'b0;
            cPass_q     <= 1'b0;
            cZ_q        <= '0;
            cAddr_q     <= '0;
            dValid_q    <= 1'b0;
            dPass_q     <= 1'b0;
            dZ_q        <= '0;
            dAddr_q     <= '0;
            passCount_q <= '0;
        end else begin
            aValid_q <= accept;
            aInb_q   <= aInb_d;
            aZ_q     <= fz[11:0];
            aAddr_q  <= aAddr_d;
            bValid_q <= aValid_q;
            bInb_q   <= aInb_q;
            bZ_q     <= aZ_q;
            bAddr_q  <= aAddr_q;
            cValid_q <= bValid_q;
            cPass_q  <= cPass_d;
            cZ_q     <= bZ_q;
            cAddr_q  <= bAddr_q;
            dValid_q <= cValid_q;
            dPass_q  <= cPass_q;
            dZ_q     <= cZ_q;
            dAddr_q  <= cAddr_q;
            if (cPass_q) begin
                passCount_q <= passCount_q + 32'd1;
            end
        end
    end

    // Reset lands in CLEAR so the depth store is always initialised before use.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= CLEAR;
            clearPending_q <= 1'b0;
            clrCnt_q       <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (clear_start) begin
                        state_q        <= DRAIN;
                        clearPending_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (!aValid_q && !bValid_q && !cValid_q && !dValid_q) begin
                        state_q        <= CLEAR;
                        clearPending_q <= 1'b0;
                        clrCnt_q       <= '0;
                    end
                end
                CLEAR: begin
                    clrCnt_q <= clrCnt_q + 1'b1;
                    if (clrCnt_q == LAST_ADDR) begin
                        state_q  <= RUN;
                        clrCnt_q <= '0;
                    end
                end
                default: begin
                    state_q <= CLEAR;
                end
            endcase
        end
    end

    depth_bram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_depth_bram (
        .clk     (clk),
        .we_i    (bramWe),
        .waddr_i (bramWaddr),
        .wdata_i (bramWdata),
        .raddr_i (aAddr_q),
        .rdata_o (bramRdata)
    );

    assign fb_we      = dPass_q;
    assign fb_addr    = dAddr_q;
    assign pass_count = passCount_q;

endmodule

// File: tb/tb_depth_test.sv
// Directed and random checks of depth_test against an in-order reference
// model: a depth array updated at accept time plus a 3-deep latency queue.
module tb_depth_test;
    import depth_test_pkg::*;

    // A short framebuffer keeps each full clear to a few thousand cycles.
    localparam int MW = 320;
    localparam int MH = 8;
    localparam int AW = 12;
    localparam int N  = MW * MH;

    logic          clk = 1'b0;
    logic          rst;
    logic          frag_valid;
    logic          frag_ready;
    vec3_i13       rast_pt;
    i13            image_width;
    i13            image_height;
    logic          clear_start;
    logic          busy;
    logic          fb_we;
    logic [AW-1:0] fb_addr;
    logic [31:0]   pass_count;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
    } exp_t;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc;
    logic [11:0] refDepth [N];
    exp_t        expQ [$];
    logic [31:0] expCount;

    depth_test #(
        .MAX_W  (MW),
        .MAX_H  (MH),
        .ADDR_W (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frag_valid   (frag_valid),
        .frag_ready   (frag_ready),
        .rast_pt      (rast_pt),
        .image_width  (image_width),
        .image_height (image_height),
        .clear_start  (clear_start),
        .busy         (busy),
        .fb_we        (fb_we),
        .fb_addr      (fb_addr),
        .pass_count   (pass_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelClearDepth();
        for (int i = 0; i < N; i++) begin
            refDepth[i] = 12'hFFF;
        end
    endtask

    task automatic resetDut();
        rst         = 1'b1;
        frag_valid  = 1'b0;
        clear_start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        expQ.delete();
        repeat (3) expQ.push_back('0);
        expCount = '0;
        modelClearDepth();
    endtask

    // One clock: drive inputs, model the fragment, then check the outputs due now.
    task automatic applyStimulus(input logic v, input int x, input int y, input int z, input logic clr);
        exp_t e;
        int   addr;
        e              = '0;
        frag_valid     = v;
        rast_pt[0]     = i13'(x);
        rast_pt[1]     = i13'(y);
        rast_pt[2]     = i13'(z);
        clear_start    = clr;
        if (v) begin
            checkOutput("frag_ready", {31'd0, frag_ready}, 32'd1);
            if (x >= 0 && x < image_width && y >= 0 && y < image_height && z >= 0) begin
                addr = y * image_width + x;
                if ((z & 4095) < refDepth[addr]) begin
                    refDepth[addr] = 12'(z & 4095);
                    e.we   = 1'b1;
                    e.addr = AW'(addr);
                end
            end
        end
        @(posedge clk);
        #1;
        frag_valid  = 1'b0;
        clear_start = 1'b0;
        expQ.push_back(e);
        e = expQ.pop_front();
        if (e.we) expCount++;
        checkOutput("fb_we", {31'd0, fb_we}, {31'd0, e.we});
        if (e.we) checkOutput("fb_addr", {20'd0, fb_addr}, {20'd0, e.addr});
        checkOutput("pass_count", pass_count, expCount);
    endtask

    task automatic waitIdle(input int bound, output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < bound) begin
            cycles++;
            applyStimulus(1'b0, 0, 0, 0, 1'b0);
        end
        checkOutput("busy_timeout", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        frag_valid   = 1'b0;
        rast_pt      = '0;
        image_width  = 13'sd320;
        image_height = 13'sd8;
        clear_start  = 1'b0;

        resetDut();
        checkOutput("rst_busy", {31'd0, busy}, 32'd1);
        checkOutput("rst_ready", {31'd0, frag_ready}, 32'd0);
        checkOutput("rst_fb_we", {31'd0, fb_we}, 32'd0);
        checkOutput("rst_fb_addr", {20'd0, fb_addr}, 32'd0);
        checkOutput("rst_pass_count", pass_count, 32'd0);
        waitIdle(N + 100, cyc);
        checkOutput("clear_len", cyc, N);
        checkOutput("ready_after_clear", {31'd0, frag_ready}, 32'd1);

        applyStimulus(1'b1, 10, 5, 100, 1'b0);
        repeat (2) applyStimulus(1'b0, 0, 0, 0, 1'b0);
        applyStimulus(1'b0, 0, 0, 0, 1'b0);
        checkOutput("single_addr", {20'd0, fb_addr}, 32'd1610);
        checkOutput("single_count", pass_count, 32'd1);

        applyStimulus(1'b1, 7, 7, 200, 1'b0);
        applyStimulus(1'b1, 7, 7, 300, 1'b0);
        applyStimulus(1'b1, 7, 7, 150, 1'b0);
        applyStimulus(1'b1, 7, 7, 150, 1'b0);
        repeat (3) applyStimulus(1'b0, 0, 0, 0, 1'b0);
        checkOutput("fwd_count", pass_count, 32'd3);

        applyStimulus(1'b1, 320, 0, 5, 1'b0);
        applyStimulus(1'b1, 0, -1, 5, 1'b0);
        applyStimulus(1'b1, 3, 3, -2, 1'b0);
        repeat (3) applyStimulus(1'b0, 0, 0, 0, 1'b0);
        checkOutput("reject_count", pass_count, 32'd3);

        // Tiny window so random fragments collide on addresses and hit edges.
        image_width  = 13'sd4;
        image_height = 13'sd3;
        for (int i = 0; i < 300; i++) begin
            applyStimulus($urandom_range(0, 3) != 0,
                          int'($urandom_range(0, 6)) - 1,
                          int'($urandom_range(0, 4)) - 1,
                          int'($urandom_range(0, 4195)) - 100,
                          1'b0);
        end
        repeat (4) applyStimulus(1'b0, 0, 0, 0, 1'b0);
        image_width  = 13'sd320;
        image_height = 13'sd8;

        applyStimulus(1'b1, 100, 2, 10, 1'b0);
        applyStimulus(1'b1, 101, 2, 20, 1'b0);
        applyStimulus(1'b1, 102, 2, 30, 1'b0);
        applyStimulus(1'b0, 0, 0, 0, 1'b1);
        modelClearDepth();
        checkOutput("busy_after_clear_start", {31'd0, busy}, 32'd1);
        repeat (100) applyStimulus(1'b0, 0, 0, 0, 1'b0);
        applyStimulus(1'b0, 0, 0, 0, 1'b1);
        waitIdle(N + 100, cyc);
        checkOutput("clear_busy_bounded", {31'd0, (cyc + 101) <= (N + 20)}, 32'd1);
        applyStimulus(1'b1, 10, 5, 4000, 1'b0);
        repeat (3) applyStimulus(1'b0, 0, 0, 0, 1'b0);
        checkOutput("post_clear_pass", {31'd0, fb_we}, 32'd1);

        resetDut();
        repeat (1000) applyStimulus(1'b0, 0, 0, 0, 1'b0);
        checkOutput("busy_mid_clear", {31'd0, busy}, 32'd1);
        resetDut();
        checkOutput("rerst_pass_count", pass_count, 32'd0);
        waitIdle(N + 100, cyc);
        checkOutput("reclear_len", cyc, N);
        applyStimulus(1'b1, 10, 5, 4000, 1'b0);
        repeat (3) applyStimulus(1'b0, 0, 0, 0, 1'b0);
        checkOutput("final_count", pass_count, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
